reg_port_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-port register block (two 32-bit data registers at addresses 0 and 1, registered read data). It accepts read/write requests from two masters over valid/ready, issues exactly one operation at a time on the target port, and returns a response with read data. Between operations the target port is parked on a side-effect-free read of the unused address.

---
 rtl/reg_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 21 ++
 rtl/reg_port_arbiter.sv | 110 +++++++++++
 tb/tb_reg_port_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-port arbiter.
// Imported by the arbiter top and its round-robin sub-module.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [1:0] DEF_IDLE_ADDR = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; purely combinational.
// The priority pointer is owned and advanced by the caller.
module rr_arb2
    import reg_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/reg_port_arbiter.sv
// Round-robin sequencer for the single-port register block: one op at a
// time, target parked on a harmless read of IDLE_ADDR between ops.
module reg_port_arbiter
    import reg_arb_pkg::*;
#(
    parameter int                ADDR_W    = 2,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = DEF_IDLE_ADDR
) (
    input  logic                clock,
    input  logic                reset_b,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_rw,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                tgt_rw,
    output logic [ADDR_W-1:0]   tgt_addr,
    output logic [DATA_W-1:0]   tgt_wdata,
    input  logic [DATA_W-1:0]   tgt_rdata,
    output logic                busy
);

    state_t              r_state;
    logic                r_rr_ptr;
    logic                r_rw;
    logic                r_id;
    logic [1:0]          r_rsp_valid;
    logic                r_tgt_rw;
    logic [ADDR_W-1:0]   r_tgt_addr;
    logic [DATA_W-1:0]   r_tgt_wdata;

    logic [1:0]          w_grant;
    logic                w_id;
    logic                w_rw;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;

    rr_arb2 u_rr_arb2 (
        .req    (req_valid),
        .rr_ptr (r_rr_ptr),
        .grant  (w_grant)
    );

    assign w_id    = w_grant[1];
    assign w_rw    = w_id ? req_rw[1] : req_rw[0];
    assign w_addr  = w_id ? req_addr[2*ADDR_W-1:ADDR_W]
                          : req_addr[ADDR_W-1:0];
    assign w_wdata = w_id ? req_wdata[2*DATA_W-1:DATA_W]
                          : req_wdata[DATA_W-1:0];

    // Ready is gated by reset so nothing looks accepted while held in reset.
    assign req_ready = (r_state == IDLE && reset_b) ? w_grant : 2'b00;

    assign busy      = (r_state != IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = (|r_rsp_valid && r_rw == RW_READ) ? tgt_rdata
                                                         : '0;
    assign tgt_rw    = r_tgt_rw;
    assign tgt_addr  = r_tgt_addr;
    assign tgt_wdata = r_tgt_wdata;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_state     <= IDLE;
            r_rr_ptr    <= 1'b0;
            r_rw        <= 1'b0;
            r_id        <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_tgt_rw    <= RW_READ;
            r_tgt_addr  <= IDLE_ADDR;
            r_tgt_wdata <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_state     <= ISSUE;
                        r_rw        <= w_rw;
                        r_id        <= w_id;
                        r_rr_ptr    <= ~w_id;
                        r_tgt_rw    <= w_rw;
                        r_tgt_addr  <= w_addr;
                        r_tgt_wdata <= w_wdata;
                    end
                end
                ISSUE: begin
                    r_state     <= CAPTURE;
                    r_rsp_valid <= r_id ? 2'b10 : 2'b01;
                    r_tgt_rw    <= RW_READ;
                    r_tgt_addr  <= IDLE_ADDR;
                    r_tgt_wdata <= '0;
                end
                CAPTURE: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 2'b00;
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 2'b00;
                    r_tgt_rw    <= RW_READ;
                    r_tgt_addr  <= IDLE_ADDR;
                    r_tgt_wdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter with a behavioural two-register
// target and a per-cycle monitor on the parked port and grant shape.
module tb_reg_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_b = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_rw = '0;
    logic [3:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        tgt_rw;
    logic [1:0]  tgt_addr;
    logic [31:0] tgt_wdata;
    logic [31:0] tgt_rdata = '0;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem [2];

    always #5 clock = ~clock;

    reg_port_arbiter dut (
        .clock     (clock),
        .reset_b   (reset_b),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .tgt_rw    (tgt_rw),
        .tgt_addr  (tgt_addr),
        .tgt_wdata (tgt_wdata),
        .tgt_rdata (tgt_rdata),
        .busy      (busy)
    );

    // Register block: commit writes, registered read data.
    initial begin
        mem[0] = '0;
        mem[1] = '0;
    end

    always @(posedge clock) begin
        if (!tgt_rw && tgt_addr < 2)
            mem[tgt_addr[0]] <= tgt_wdata;
        tgt_rdata <= (tgt_addr < 2) ? mem[tgt_addr[0]]
                                    : (32'hBAD0_0000 | 32'(tgt_addr));
    end

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    // Monitor: write strobe only in ISSUE, parked port otherwise.
    always @(negedge clock) begin
        check("mon_onehot", 32'($countones(req_ready) > 1), 0);
        check("mon_wr_issue",
              32'(!tgt_rw && !(busy && rsp_valid == 2'b00)), 0);
        if (!busy || rsp_valid != 2'b00)
            check("mon_park", {tgt_wdata[28:0], tgt_rw, tgt_addr},
                  {29'd0, 1'b1, 2'b11});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset_b = 1'b0;
        tick();
        tick();
        reset_b = 1'b1;
    endtask

    task automatic do_op(int id, logic rw, logic [1:0] a,
                         logic [31:0] wd, logic [31:0] exp);
        int n;
        req_valid[id]          = 1'b1;
        req_rw[id]             = rw;
        req_addr[id*2 +: 2]    = a;
        req_wdata[id*32 +: 32] = wd;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("op_timeout", 1, 0);
        tick();
        req_valid[id] = 1'b0;
        check("op_issue_rw", 32'(tgt_rw), 32'(rw));
        check("op_issue_addr", 32'(tgt_addr), 32'(a));
        tick();
        check("op_rsp_valid", 32'(rsp_valid), 32'(2'b01 << id));
        check("op_rsp_rdata", rsp_rdata, exp);
        tick();
        check("op_idle", 32'({busy, rsp_valid}), 0);
    endtask

    initial begin
        int g;
        int r0;
        int r1;
        logic nxt;

        // Reset state, with a request pending to confirm ready is held low
        req_valid = 2'b01;
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp", 32'(rsp_valid), 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_tgt", {tgt_wdata[28:0], tgt_rw, tgt_addr},
              {29'd0, 1'b1, 2'b11});
        req_valid = 2'b00;
        reset_b = 1'b1;

        // Write then read back on requester 0
        do_op(0, 1'b0, 2'd0, 32'hDEADBEEF, 32'h0);
        do_op(0, 1'b1, 2'd0, 32'h0, 32'hDEADBEEF);

        // Simultaneous requests from rr_ptr = 0
        pulse_reset();
        req_rw     = 2'b00;
        req_addr   = {2'd1, 2'd0};
        req_wdata  = {32'h22222222, 32'h11111111};
        req_valid  = 2'b11;
        #1;
        check("both_grant0", 32'(req_ready), 32'(2'b01));
        tick();
        req_valid[0] = 1'b0;
        check("both_issue_ready", 32'(req_ready), 0);
        check("both_issue_addr", 32'(tgt_addr), 0);
        tick();
        check("both_rsp0", 32'(rsp_valid), 32'(2'b01));
        check("both_cap_ready", 32'(req_ready), 0);
        tick();
        check("both_grant1", 32'(req_ready), 32'(2'b10));
        tick();
        req_valid[1] = 1'b0;
        check("both_issue1", tgt_wdata, 32'h22222222);
        tick();
        check("both_rsp1", 32'(rsp_valid), 32'(2'b10));
        tick();
        do_op(0, 1'b1, 2'd0, 32'h0, 32'h11111111);
        do_op(1, 1'b1, 2'd1, 32'h0, 32'h22222222);

        // Six back-to-back ops per requester, strict alternation
        req_rw    = 2'b11;
        req_addr  = {2'd1, 2'd0};
        req_valid = 2'b11;
        #1;
        g   = 0;
        r0  = 0;
        r1  = 0;
        nxt = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (rsp_valid[0]) r0++;
            if (rsp_valid[1]) r1++;
            if (req_ready != 2'b00 && g < 12) begin
                check("alt_grant", 32'(req_ready), 32'(2'b01 << nxt));
                nxt = ~nxt;
                g++;
            end
            tick();
            if (g == 12) req_valid = 2'b00;
        end
        check("alt_grants", 32'(g), 12);
        check("alt_rsp0", 32'(r0), 6);
        check("alt_rsp1", 32'(r1), 6);

        // Reset mid-CAPTURE of a read
        req_valid[0] = 1'b1;
        req_rw[0]    = 1'b1;
        req_addr     = {2'd1, 2'd0};
        #1;
        tick();
        req_valid[0] = 1'b0;
        tick();
        check("rc_rsp_before", 32'(rsp_valid), 32'(2'b01));
        #2;
        reset_b = 1'b0;
        #1;
        check("rc_rsp", 32'(rsp_valid), 0);
        check("rc_busy", 32'(busy), 0);
        check("rc_tgt", {tgt_wdata[28:0], tgt_rw, tgt_addr},
              {29'd0, 1'b1, 2'b11});
        tick();
        reset_b = 1'b1;
        do_op(1, 1'b1, 2'd1, 32'h0, 32'h22222222);

        // Write to unmapped address leaves the registers alone
        do_op(0, 1'b0, 2'd2, 32'hFFFFFFFF, 32'h0);
        do_op(0, 1'b1, 2'd0, 32'h0, 32'h11111111);
        do_op(1, 1'b1, 2'd1, 32'h0, 32'h22222222);

        tick();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
